// File: rtl/mips_alu_scheduler.sv
// rtl/mips_alu_scheduler.sv - two-requester round-robin front end for a shared combinational MIPS ALU
module mips_alu_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_ins,
  input  logic [31:0]      req0_rega,
  input  logic [31:0]      req0_regb,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_ins,
  input  logic [31:0]      req1_rega,
  input  logic [31:0]      req1_regb,
  output logic [31:0]      alu_ins,
  output logic [31:0]      alu_rega,
  output logic [31:0]      alu_regb,
  input  logic [31:0]      alu_result,
  input  logic [2:0]       alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic [2:0]       rsp_flag,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic [31:0] ins_q;
  logic [31:0] rega_q;
  logic [31:0] regb_q;
  logic        id_q;
  logic        grant_any;
  logic        grant_id;
  logic        supported;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  assign opcode = ins_q[31:26];
  assign funct  = ins_q[5:0];

  // Ready is a combinational grant; it is masked during reset so every output reads 0 then.
  always_comb begin
    state_nxt  = state;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          grant_any = 1'b1;
          if (req0_valid && req1_valid) grant_id = ~last_grant;
          else                          grant_id = req1_valid;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    supported = 1'b0;
    if (opcode == 6'd0) begin
      case (funct)
        6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd42, 6'd43: supported = 1'b1;
        default: supported = (funct[5:3] == 3'b100);
      endcase
    end else begin
      case (opcode)
        6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43: supported = 1'b1;
        default: supported = 1'b0;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign alu_ins   = (state == IDLE) ? 32'd0 : ins_q;
  assign alu_rega  = (state == IDLE) ? 32'd0 : rega_q;
  assign alu_regb  = (state == IDLE) ? 32'd0 : regb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      ins_q      <= 32'd0;
      rega_q     <= 32'd0;
      regb_q     <= 32'd0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_flag   <= 3'd0;
      rsp_err    <= 1'b0;
      done_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        ins_q      <= grant_id ? req1_ins  : req0_ins;
        rega_q     <= grant_id ? req1_rega : req0_rega;
        regb_q     <= grant_id ? req1_regb : req0_regb;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_id     <= id_q;
        rsp_err    <= ~supported;
        rsp_result <= supported ? alu_result : 32'd0;
        rsp_flag   <= supported ? alu_flag : 3'd0;
      end
      if (state == RESP && rsp_ready) done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_alu_scheduler.sv
// tb/tb_mips_alu_scheduler.sv - scoreboard bench for mips_alu_scheduler with a small reference ALU
module tb_mips_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_ins = '0, req0_rega = '0, req0_regb = '0;
  logic [31:0] req1_ins = '0, req1_rega = '0, req1_regb = '0;
  logic [31:0] alu_ins, alu_rega, alu_regb, alu_result;
  logic [2:0]  alu_flag;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flag;
  logic [3:0]  done_cnt;

  mips_alu_scheduler #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ins(req0_ins), .req0_rega(req0_rega), .req0_regb(req0_regb),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ins(req1_ins), .req1_rega(req1_rega), .req1_regb(req1_regb),
    .alu_ins(alu_ins), .alu_rega(alu_rega), .alu_regb(alu_regb),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Negative flag reports the sign of the exact result, so signed overflow flips the raw sign bit.
  logic alu_ovf;
  always_comb begin
    alu_result = alu_rega ^ alu_regb;
    alu_ovf    = 1'b0;
    if (alu_ins[31:26] == 6'd0) begin
      case (alu_ins[5:0])
        6'd32: begin
          alu_result = alu_rega + alu_regb;
          alu_ovf    = (alu_rega[31] == alu_regb[31]) && (alu_result[31] != alu_rega[31]);
        end
        6'd34: begin
          alu_result = alu_rega - alu_regb;
          alu_ovf    = (alu_rega[31] != alu_regb[31]) && (alu_result[31] != alu_rega[31]);
        end
        6'd36:   alu_result = alu_rega & alu_regb;
        6'd37:   alu_result = alu_rega | alu_regb;
        default: alu_result = alu_rega ^ alu_regb;
      endcase
    end
    alu_flag = {alu_result == 32'd0, alu_result[31] ^ alu_ovf, alu_ovf};
  end

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic [2:0]  flag;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_rsp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_cur = exp_q.pop_front();
        check("rsp_id",     32'(rsp_id),     32'(exp_cur.id));
        check("rsp_result", rsp_result,      exp_cur.res);
        check("rsp_flag",   32'(rsp_flag),   32'(exp_cur.flag));
        check("rsp_err",    32'(rsp_err),    32'(exp_cur.err));
      end
      n_rsp++;
    end
  end

  task automatic push(input logic id, input logic [31:0] res, input logic [2:0] flag, input logic err);
    exp_t e;
    e.id = id; e.res = res; e.flag = flag; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic id, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    if (id) begin req1_ins = ins; req1_rega = a; req1_regb = b; req1_valid = 1'b1; end
    else    begin req0_ins = ins; req0_rega = a; req0_regb = b; req0_valid = 1'b1; end
    #1;
    while (!(id ? req1_ready : req0_ready) && k < 20) begin
      @(posedge clk); #2; k++;
    end
    check("accept_timeout", 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int k = 0;
    while (n_rsp < target && k < 50) begin
      @(posedge clk); #2; k++;
    end
    check("rsp_timeout", 32'(n_rsp >= target), 32'd1);
  endtask

  task automatic run_one(input logic id, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [2:0] flag, input logic err);
    int tgt;
    tgt = n_rsp + 1;
    push(id, res, flag, err);
    issue(id, ins, a, b);
    wait_rsp(tgt);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #2; k++;
    end
    check("valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int base;
    // Reset: outputs zero even with a request pending.
    req0_valid = 1'b1;
    #2;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_done_cnt",   32'(done_cnt),   32'd0);
    check("rst_alu_ins",    alu_ins,         32'd0);
    req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Signed add overflow, cycle by cycle.
    push(1'b0, 32'h8000_0000, 3'b001, 1'b0);
    req0_ins = 32'h0000_0020; req0_rega = 32'h7FFF_FFFF; req0_regb = 32'h0000_0001; req0_valid = 1'b1;
    #1;
    check("a_req0_ready", 32'(req0_ready), 32'd1);
    check("a_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1;
    check("a_exec_ready", 32'(req0_ready), 32'd0);
    check("a_exec_alu",   alu_ins,         32'h0000_0020);
    check("a_exec_rega",  alu_rega,        32'h7FFF_FFFF);
    check("a_exec_valid", 32'(rsp_valid),  32'd0);
    @(posedge clk); #2;
    check("a_resp_valid", 32'(rsp_valid),  32'd1);
    @(posedge clk); #2;
    check("a_done_cnt",   32'(done_cnt),   32'd1);
    check("a_idle_alu",   alu_ins,         32'd0);

    // Round robin from reset: 0,1,0,1.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    push(1'b0, 32'hF000_F000, 3'b010, 1'b0);
    push(1'b1, 32'h0000_0000, 3'b100, 1'b0);
    push(1'b0, 32'hF000_F000, 3'b010, 1'b0);
    push(1'b1, 32'h0000_0000, 3'b100, 1'b0);
    req0_ins = 32'h0000_0024; req0_rega = 32'hF0F0_F0F0; req0_regb = 32'hFF00_FF00;
    req1_ins = 32'h0000_0022; req1_rega = 32'd7;         req1_regb = 32'd7;
    base = n_rsp;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_rsp(base + 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_done_cnt", 32'(done_cnt), 32'd4);

    // Back-pressure: response held for five cycles.
    rsp_ready = 1'b0;
    push(1'b1, 32'h0000_567C, 3'b000, 1'b0);
    issue(1'b1, 32'h0000_0025, 32'h0000_1234, 32'h0000_5678);
    wait_valid();
    req0_ins = 32'h0000_0020; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("stall_valid",  32'(rsp_valid),  32'd1);
      check("stall_result", rsp_result,      32'h0000_567C);
      check("stall_id",     32'(rsp_id),     32'd1);
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_done",   32'(done_cnt),   32'd4);
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    check("stall_release_done", 32'(done_cnt), 32'd5);
    check("stall_release_idle", alu_ins,       32'd0);

    // Unsupported and boundary decodes.
    run_one(1'b1, 32'hFC00_0000, 32'h55, 32'hAA, 32'd0, 3'b000, 1'b1);
    run_one(1'b0, 32'h8C00_0000, 32'd3,  32'd4,  32'd7, 3'b000, 1'b0);
    run_one(1'b0, 32'h0000_0001, 32'd3,  32'd4,  32'd0, 3'b000, 1'b1);
    check("decode_done", 32'(done_cnt), 32'd8);

    // Reset during RESP discards the operation.
    rsp_ready = 1'b0;
    issue(1'b1, 32'h0000_0020, 32'd1, 32'd2);
    wait_valid();
    #1; rst = 1'b1; #1;
    check("mid_rst_valid",  32'(rsp_valid), 32'd0);
    check("mid_rst_result", rsp_result,     32'd0);
    check("mid_rst_id",     32'(rsp_id),    32'd0);
    check("mid_rst_done",   32'(done_cnt),  32'd0);
    check("mid_rst_alu",    alu_rega,       32'd0);
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    base = n_rsp;
    repeat (4) @(posedge clk);
    #2;
    check("mid_rst_no_rsp", 32'(n_rsp), 32'(base));
    req0_ins = 32'h0000_0020; req0_rega = 32'd2; req0_regb = 32'd3;
    req1_ins = 32'h0000_0020; req1_valid = 1'b1; req0_valid = 1'b1;
    #1;
    check("tie_ready0", 32'(req0_ready), 32'd1);
    check("tie_ready1", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    run_one(1'b0, 32'h0000_0020, 32'd2, 32'd3, 32'd5, 3'b000, 1'b0);
    check("post_rst_done", 32'(done_cnt), 32'd1);

    // Counter wrap at 4 bits.
    for (int i = 0; i < 14; i++)
      run_one(1'b0, 32'h0000_0025, 32'(i + 1), 32'd0, 32'(i + 1), 3'b000, 1'b0);
    check("wrap_full", 32'(done_cnt), 32'd15);
    run_one(1'b1, 32'h0000_0025, 32'd9, 32'd6, 32'd15, 3'b000, 1'b0);
    check("wrap_zero", 32'(done_cnt), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
